// File: rtl/ccc_cfg_pkg.sv
// ccc_cfg_pkg: shared types and constants for the CCC dynamic-configuration
// APB master (sequencer state, status codes, APB bus widths).
package ccc_cfg_pkg;

  localparam int unsigned APB_ADDR_W = 6;
  localparam int unsigned APB_DATA_W = 8;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_VERIFY  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WR_SETUP,
    ST_WR_ACCESS,
    ST_RD_SETUP,
    ST_RD_ACCESS,
    ST_CHECK,
    ST_RELEASE,
    ST_WAIT_LOCK,
    ST_FINISH
  } cfg_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level signal.
//   clk - destination clock
//   rst - asynchronous active-high reset (output clears to 0)
//   d   - asynchronous input
//   q   - synchronised output, two clk edges after d
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// ccc_apb_cfg_master: APB initiator for the CCC dynamic-configuration port.
// On CFG_START it holds the PLL in reset, writes NUM_REGS bytes, reads each
// back and verifies it, releases the PLL and waits for a qualified LOCK.
//   CLK, RESET        - fabric clock (also CCC PCLK), async active-high reset
//   CFG_START/DATA    - start request and config bytes (byte i at [8i+7:8i])
//   BUSY, DONE, ERR   - status: busy level, end pulse, 0 ok/1 verify/2 timeout
//   LOCKED            - synchronised LOCK, masked while BUSY
//   PLL_ARST_N        - PLL reset to the CCC (low while configuring)
//   PRESET_N          - APB reset to the CCC
//   PSEL..PRDATA      - APB master bus (fixed 2-cycle transfers, no PREADY)
//   LOCK              - CCC lock, asynchronous to CLK
module ccc_apb_cfg_master
  import ccc_cfg_pkg::*;
#(
  parameter int unsigned           NUM_REGS     = 4,
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR    = 6'h00,
  parameter int unsigned           RST_HOLD     = 16,
  parameter int unsigned           LOCK_STABLE  = 8,
  parameter int unsigned           LOCK_TIMEOUT = 65535
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CFG_START,
  input  logic [NUM_REGS*8-1:0] CFG_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [1:0]            ERR,
  output logic                  LOCKED,
  output logic                  PLL_ARST_N,
  output logic                  PRESET_N,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_ADDR_W-1:0] PADDR,
  output logic [APB_DATA_W-1:0] PWDATA,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  LOCK
);

  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(LOCK_STABLE);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(LOCK_TIMEOUT);

  if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
    $error("NUM_REGS must be in 1..16");
  end
  if (32'(BASE_ADDR) + NUM_REGS - 1 > 32'd63) begin : g_bad_addr_range
    $error("BASE_ADDR+NUM_REGS-1 exceeds the 6-bit APB address space");
  end
  if (RST_HOLD < 1 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1) begin : g_bad_counts
    $error("RST_HOLD, LOCK_STABLE and LOCK_TIMEOUT must be at least 1");
  end

  cfg_state_e            state_q, state_d;
  logic [APB_DATA_W-1:0] cfg_q [NUM_REGS];
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [STAB_W-1:0]     stab_q, stab_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic [1:0]            err_q, err_d;
  logic [APB_DATA_W-1:0] rd_q;
  logic [APB_DATA_W-1:0] cur_byte;
  logic                  preset_q;
  logic                  lock_s;
  logic                  accept;
  logic                  in_xfer;

  sync_2ff u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (LOCK),
    .q   (lock_s)
  );

  assign cur_byte = cfg_q[idx_q];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      hold_q   <= '0;
      stab_q   <= '0;
      tmo_q    <= '0;
      err_q    <= ERR_OK;
      rd_q     <= '0;
      preset_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) cfg_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      stab_q   <= stab_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
      preset_q <= 1'b1;
      if (accept) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) cfg_q[i] <= CFG_DATA[8*i +: 8];
      end
      // PRDATA is taken on the edge that ends the read ACCESS cycle.
      if (state_q == ST_RD_ACCESS) rd_q <= PRDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    stab_d  = stab_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (CFG_START) begin
          accept  = 1'b1;
          err_d   = ERR_OK;
          hold_d  = '0;
          idx_d   = '0;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          idx_d   = '0;
          state_d = ST_WR_SETUP;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_WR_SETUP: state_d = ST_WR_ACCESS;
      ST_WR_ACCESS: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_RD_SETUP;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_WR_SETUP;
        end
      end
      ST_RD_SETUP:  state_d = ST_RD_ACCESS;
      ST_RD_ACCESS: state_d = ST_CHECK;
      ST_CHECK: begin
        if (rd_q != cur_byte) begin
          err_d   = ERR_VERIFY;
          state_d = ST_RELEASE;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_RELEASE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_RD_SETUP;
        end
      end
      ST_RELEASE: begin
        stab_d  = '0;
        tmo_d   = '0;
        state_d = (err_q == ERR_VERIFY) ? ST_FINISH : ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        tmo_d  = tmo_q + 1'b1;
        stab_d = lock_s ? stab_q + 1'b1 : '0;
        // Stability is tested first so a simultaneous timeout still succeeds.
        if (stab_d == STAB_MAX) begin
          state_d = ST_FINISH;
        end else if (tmo_d == TMO_MAX) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decode directly from the state register so an asynchronous
  // RESET returns every one of them to its idle value immediately.
  always_comb begin
    in_xfer    = state_q inside {ST_WR_SETUP, ST_WR_ACCESS, ST_RD_SETUP, ST_RD_ACCESS};
    BUSY       = (state_q != ST_IDLE);
    DONE       = (state_q == ST_FINISH);
    ERR        = err_q;
    LOCKED     = lock_s & ~BUSY;
    PLL_ARST_N = !(in_xfer || state_q inside {ST_HOLD, ST_CHECK});
    PRESET_N   = preset_q;
    PSEL       = in_xfer;
    PENABLE    = state_q inside {ST_WR_ACCESS, ST_RD_ACCESS};
    PWRITE     = state_q inside {ST_WR_SETUP, ST_WR_ACCESS};
    PADDR      = in_xfer ? BASE_ADDR + APB_ADDR_W'(idx_q) : '0;
    PWDATA     = PWRITE ? cur_byte : '0;
  end

endmodule

// File: doc/ccc_apb_cfg_master.md
Name: ccc_apb_cfg_master

Overview:
- APB initiator that drives the CCC dynamic-configuration port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA), which is otherwise tied off.
- On request it:
  - holds the PLL in reset;
  - writes a block of configuration bytes;
  - reads each byte back and verifies it;
  - releases the PLL and waits for a qualified LOCK.
- Sits in the fabric clock domain beside the CCC wrapper and reports status to the system controller.

Parameters:
- NUM_REGS, 4, number of consecutive CCC config bytes written and verified (1..16).
- BASE_ADDR, 6'h00, PADDR of the first byte; byte i is written at BASE_ADDR+i.
- RST_HOLD, 16, cycles PLL_ARST_N is held low before the first APB write.
- LOCK_STABLE, 8, consecutive synchronised-LOCK-high cycles required for success.
- LOCK_TIMEOUT, 65535, maximum WAIT_LOCK cycles before a timeout error.

Ports:
- CLK  in  1  fabric clock; also drives the CCC PCLK.
- RESET  in  1  asynchronous, active-high reset.
- CFG_START  in  1  single-cycle request; ignored while BUSY=1.
- CFG_DATA  in  NUM_REGS*8  config bytes, byte i at [8i+7:8i]; captured when CFG_START is accepted.
- BUSY  out  1  sequence in progress.
- DONE  out  1  one-cycle pulse at the end of a sequence.
- ERR  out  2  status held until the next accepted CFG_START: 0 ok, 1 readback mismatch, 2 lock timeout.
- LOCKED  out  1  synchronised LOCK, masked to 0 while BUSY=1.
- PLL_ARST_N  out  1  to CCC PLL_ARST_N.
- PRESET_N  out  1  to CCC PRESET_N.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB write strobe.
- PADDR  out  6  APB address.
- PWDATA  out  8  APB write data.
- PRDATA  in  8  APB read data.
- LOCK  in  1  CCC LOCK; asynchronous to CLK.

Behaviour:
- Reset (asynchronous, active-high) values:
  - BUSY=0, DONE=0, ERR=0, LOCKED=0, PLL_ARST_N=1, PRESET_N=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
  - FSM=IDLE; byte index and all counters =0.
- PRESET_N is registered and rises on the first CLK edge after RESET deasserts.
- LOCK passes through a 2-flop synchroniser (lock_s). Outside BUSY, LOCKED = lock_s.
- APB timing: no PREADY; every transfer is exactly 2 cycles.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
  - Outside transfers, PSEL/PENABLE=0.
  - PRDATA is sampled on the clock edge that ends ACCESS.
  - PADDR/PWRITE/PWDATA are stable across both cycles.
- FSM states and transitions:
  - IDLE: if CFG_START, capture CFG_DATA, set ERR=0, BUSY=1, go to HOLD.
  - HOLD: PLL_ARST_N=0; count RST_HOLD cycles, then go to WR_SETUP with idx=0.
  - WR_SETUP -> WR_ACCESS: PWRITE=1, PADDR=BASE_ADDR+idx, PWDATA=byte[idx]. After ACCESS, idx++. If idx==NUM_REGS-1, set idx=0 and go to RD_SETUP instead.
  - RD_SETUP -> RD_ACCESS: PWRITE=0, PADDR=BASE_ADDR+idx. Then go to CHECK.
  - CHECK (1 cycle): compare the sampled byte with byte[idx].
    - Mismatch: ERR=1, go to RELEASE.
    - Match and last index: go to RELEASE.
    - Otherwise: idx++, go to RD_SETUP.
  - RELEASE (1 cycle): PLL_ARST_N=1. If ERR=1 go to FINISH, else go to WAIT_LOCK with counters cleared.
  - WAIT_LOCK: the timeout counter increments every cycle.
    - Stable counter increments while lock_s=1 and clears when lock_s=0.
    - When stable==LOCK_STABLE, go to FINISH.
    - When timeout==LOCK_TIMEOUT, set ERR=2 and go to FINISH. If both conditions hit in the same cycle, success wins.
  - FINISH (1 cycle): DONE=1, BUSY=0 on the next cycle, go to IDLE.
- Address arithmetic is modulo 64. BASE_ADDR+NUM_REGS-1 > 63 is an elaboration error.
- Cycle counts with no errors: from the CFG_START edge, PLL_ARST_N falls 1 cycle later. The first PSEL occurs RST_HOLD cycles after that.
- Simultaneous events:
  - CFG_START in the same cycle as FINISH is ignored.
  - LOCK glitches during WAIT_LOCK restart the stability count but not the timeout.
- RESET mid-sequence aborts immediately:
  - all outputs return to their reset values, including PLL_ARST_N=1 (PLL resumes on its static config);
  - no DONE pulse is produced.

Decomposition:
- Shared package ccc_cfg_pkg holds:
  - the FSM state enum;
  - the ERR codes (ERR_OK, ERR_VERIFY, ERR_TIMEOUT);
  - the APB address width constant (6) and data width constant (8).
- One sub-module, sync_2ff, for the LOCK synchroniser; it is reusable elsewhere.
- Counters and APB sequencing stay in the top module.

Test Plan (NUM_REGS=4, RST_HOLD=16, LOCK_STABLE=8, LOCK_TIMEOUT=200, BASE_ADDR=6'h10):
1. Reset then idle -> all outputs hold their reset values; PRESET_N=1 one cycle after RESET falls; no PSEL activity.
2. CFG_START with CFG_DATA=32'hA1B2C3D4; the APB model echoes writes; LOCK rises 20 cycles after RELEASE -> writes appear in order:
   - 6'h10=D4, 6'h11=C3, 6'h12=B2, 6'h13=A1;
   - then 4 reads of the same addresses;
   - each transfer is exactly 2 cycles;
   - DONE pulses once with ERR=0, then LOCKED=1.
3. APB model corrupts the readback of 6'h12 (returns 8'h00) -> no read of 6'h13; PLL_ARST_N returns to 1; DONE with ERR=1; no lock wait.
4. LOCK held low -> DONE exactly 200 cycles after entering WAIT_LOCK, ERR=2.
5. LOCK toggles every 5 cycles for 50 cycles, then stays high -> success only after 8 consecutive high cycles; ERR=0.
6. RESET asserted during WR_ACCESS of the third byte -> PSEL/PENABLE=0 and PLL_ARST_N=1 asynchronously; BUSY=0; no DONE. A subsequent CFG_START runs a full, clean sequence.
